// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall/flush bit indices,
// strobe patterns, controller state encoding and the pipeline bubble instruction.
package pipe_ctrl_pkg;

   localparam int STALL_PC    = 0;
   localparam int STALL_IF    = 1;
   localparam int STALL_ID    = 2;
   localparam int STALL_EX    = 3;
   localparam int STALL_WB    = 4;
   localparam int STALL_BUS_W = 5;

   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD_EX = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   // Bubble loaded by a flushed pipeline register (addi x0,x0,0 with we=0)
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam stall_bus_t HOLD_STALL  = stall_bus_t'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
   localparam stall_bus_t HOLD_FLUSH  = stall_bus_t'(1 << STALL_EX);
   localparam stall_bus_t JUMP_FLUSH  = stall_bus_t'((1 << STALL_IF) | (1 << STALL_ID));
   localparam stall_bus_t LU_STALL    = stall_bus_t'((1 << STALL_PC) | (1 << STALL_IF));
   localparam stall_bus_t LU_FLUSH    = stall_bus_t'(1 << STALL_ID);
   localparam stall_bus_t WIN_FLUSH   = stall_bus_t'(1 << STALL_IF);

endpackage

// File: rtl/pipe_wdt.sv
// Saturating hold counter for the pipe_ctrl watchdog; hit marks the LIMIT-th
// consecutive hold cycle (the entry cycle in RUN counts as the first).
module pipe_wdt #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam logic [7:0] HIT_AT = 8'(LIMIT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= 8'd1;
      end else if (inc && count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   assign hit = (count == HIT_AT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush strobes and PC redirect.
// Optional hold watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int WDT_LIMIT    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_hold_req,
   input  logic              ex_hold_req,
   input  logic              ex_jump_req,
   input  logic [31:0]       ex_jump_addr,
   output logic [4:0]        stall,
   output logic [4:0]        flush,
   output logic              jump_o,
   output logic [31:0]       jump_addr_o,
   output logic              busy,
   output logic              wdt_err
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || WDT_LIMIT < 2 || WDT_LIMIT > 255) begin : g_bad_param
      $error("pipe_ctrl: FLUSH_CYCLES or WDT_LIMIT out of range");
   end

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

   state_t     state, state_n;
   logic [2:0] cnt, cnt_n;
   stall_bus_t stall_c, flush_c;
   logic       jump_c;
   logic [31:0] addr_c;
   logic       hold_act;
   logic       run_rules;

`ifdef PIPE_CTRL_WDT_EN
   logic wdt_hit;
   logic wdt_inc;
   logic wdt_set;
   logic wdt_q;

   assign wdt_inc = (state == ST_HOLD_EX) && ex_hold_req && !wdt_hit;
   assign wdt_set = (state == ST_HOLD_EX) && ex_hold_req && wdt_hit;

   pipe_wdt #(.LIMIT(WDT_LIMIT)) u_wdt (
      .clk (clk),
      .rst (rst),
      .clr (hold_act),
      .inc (wdt_inc),
      .hit (wdt_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_q <= 1'b0;
      end else if (wdt_set) begin
         wdt_q <= 1'b1;
      end
   end

   assign wdt_err = wdt_q;
`else
   assign wdt_err = 1'b0;
`endif

   always_comb begin
      stall_c   = '0;
      flush_c   = '0;
      jump_c    = 1'b0;
      addr_c    = '0;
      state_n   = state;
      cnt_n     = cnt;
      hold_act  = 1'b0;
      run_rules = 1'b0;

      unique case (state)
         ST_RUN: begin
            if (ex_hold_req) hold_act = 1'b1;
            else             run_rules = 1'b1;
         end
         ST_HOLD_EX: begin
            if (ex_hold_req) begin
`ifdef PIPE_CTRL_WDT_EN
               // Forced release: outputs stay 0 and EX is drained
               if (wdt_hit) begin
                  state_n = ST_DRAIN;
               end else begin
                  stall_c = HOLD_STALL;
                  flush_c = HOLD_FLUSH;
               end
`else
               stall_c = HOLD_STALL;
               flush_c = HOLD_FLUSH;
`endif
            end else begin
               run_rules = 1'b1;
            end
         end
         ST_FLUSH: begin
            flush_c = WIN_FLUSH;
            if (cnt == 3'd0) state_n = ST_RUN;
            else             cnt_n   = cnt - 3'd1;
         end
         ST_DRAIN: begin
            run_rules = 1'b1;
         end
         default: state_n = ST_RUN;
      endcase

      if (hold_act) begin
         stall_c = HOLD_STALL;
         flush_c = HOLD_FLUSH;
         state_n = ST_HOLD_EX;
      end

      // RUN rules without the hold case; ex_hold_req is 0 or masked here
      if (run_rules) begin
         state_n = (state == ST_DRAIN && ex_hold_req) ? ST_DRAIN : ST_RUN;
         if (ex_jump_req) begin
            jump_c  = 1'b1;
            addr_c  = ex_jump_addr;
            flush_c = JUMP_FLUSH;
            if (FLUSH_CYCLES > 1) begin
               state_n = ST_FLUSH;
               cnt_n   = FLUSH_LOAD;
            end
         end else if (id_hold_req) begin
            stall_c = LU_STALL;
            flush_c = LU_FLUSH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   assign stall       = rst ? 5'd0  : stall_c;
   assign flush       = rst ? 5'd0  : flush_c;
   assign jump_o      = rst ? 1'b0  : jump_c;
   assign jump_addr_o = rst ? 32'd0 : addr_c;
   assign busy        = !rst && (state != ST_RUN);

endmodule
